// File: rtl/rpn_pkg.sv
// Shared types and character decoding for the RPN add/subtract sequencer.
package rpn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_e;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CLR   = 8'h63;
    localparam logic [7:0] CH_DUP   = 8'h64;
    localparam logic [7:0] CH_SWAP  = 8'h73;

    // Returns {is_hex, value}; only lowercase a-f are digits.
    function automatic logic [4:0] hex_char_val(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            r = {1'b1, ch[3:0]};
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            r = {1'b1, 4'(ch[3:0] + 4'd9)};
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_w.sv
// Combinational WIDTH-bit adder/subtractor; carry doubles as borrow when sub=1.
module addsub_w #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] ext;

    // The extended difference goes negative exactly when a < b.
    always_comb begin
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b};
        end else begin
            ext = {1'b0, a} + {1'b0, b};
        end
        sum   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
    end

endmodule

// File: rtl/rpn_addsub_seq.sv
// RPN character-stream front end with a DEPTH-entry operand stack and a WIDTH-bit add/sub.
// Optional 'd' (dup) / 's' (swap) commands enabled by defining RPN_DUP_SWAP_EN.
module rpn_addsub_seq
    import rpn_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_char_valid,
    input  logic [7:0]       i_char,
    output logic             o_char_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_result_valid,
    output logic [DW-1:0]    o_depth,
    output logic             o_err
);

    localparam int unsigned PW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
    logic             sub_q, sub_d, carry_q, carry_d, valid_q, valid_d, err_q, err_d;

    logic             transfer, empty, full, has_two;
    logic [PW-1:0]    top_ptr, sec_ptr, nxt_ptr;
    logic [4:0]       hex;
    logic [WIDTH-1:0] push_val, alu_sum;
    logic             alu_carry;

    addsub_w #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a    (a_q),
        .b    (b_q),
        .sub  (sub_q),
        .sum  (alu_sum),
        .carry(alu_carry)
    );

    always_comb begin
        transfer = i_char_valid && o_char_ready;
        empty    = (depth_q == '0);
        full     = (depth_q == DW'(DEPTH));
        has_two  = (depth_q >= DW'(2));
        top_ptr  = PW'(depth_q - DW'(1));
        sec_ptr  = PW'(depth_q - DW'(2));
        nxt_ptr  = PW'(depth_q);
        hex      = hex_char_val(i_char);
        push_val = WIDTH'(hex[3:0]);
    end

    always_comb begin
        state_d  = state_q;
        stack_d  = stack_q;
        depth_d  = depth_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        res_d    = res_q;
        result_d = result_q;
        carry_d  = carry_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    if (i_char == CH_CLR) begin
                        depth_d = '0;
                        err_d   = 1'b0;
`ifdef RPN_DUP_SWAP_EN
                    end else if (i_char == CH_DUP) begin
                        if (empty || full) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[nxt_ptr] = stack_q[top_ptr];
                            depth_d          = depth_q + DW'(1);
                        end
                    end else if (i_char == CH_SWAP) begin
                        if (!has_two) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[top_ptr] = stack_q[sec_ptr];
                            stack_d[sec_ptr] = stack_q[top_ptr];
                        end
`else
                    end else if (i_char == CH_DUP) begin
                        // 'd' is a command character, never a digit, even when dup is absent.
                        err_d = err_q;
`endif
                    end else if (i_char == CH_PLUS || i_char == CH_MINUS) begin
                        if (has_two) begin
                            a_d     = stack_q[sec_ptr];
                            b_d     = stack_q[top_ptr];
                            sub_d   = (i_char == CH_MINUS);
                            state_d = S_EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (i_char == CH_EQ) begin
                        if (empty) begin
                            err_d = 1'b1;
                        end else begin
                            result_d = stack_q[top_ptr];
                            carry_d  = 1'b0;
                            valid_d  = 1'b1;
                        end
                    end else if (hex[4]) begin
                        if (full) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[nxt_ptr] = push_val;
                            depth_d          = depth_q + DW'(1);
                        end
                    end
                end
            end
            // Result is published on entry to S_WB so the pulse lands two cycles after the op.
            S_EXEC: begin
                res_d    = alu_sum;
                result_d = alu_sum;
                carry_d  = alu_carry;
                valid_d  = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                stack_d[sec_ptr] = res_q;
                depth_d          = depth_q - DW'(1);
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            depth_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            res_q    <= res_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        stack_q <= stack_d;
    end

    always_comb begin
        o_char_ready   = (state_q == S_IDLE);
        o_result       = result_q;
        o_carry        = carry_q;
        o_result_valid = valid_q;
        o_depth        = depth_q;
        o_err          = err_q;
    end

endmodule

// File: tb/tb_rpn_addsub_seq.sv
// Directed self-checking bench for rpn_addsub_seq at WIDTH=4, DEPTH=4.
module tb_rpn_addsub_seq;

    logic       clk;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] char_in;
    logic       char_ready;
    logic [3:0] result;
    logic       carry;
    logic       result_valid;
    logic [2:0] depth;
    logic       err;

    int checks = 0;
    int errors = 0;

    rpn_addsub_seq #(
        .WIDTH(4),
        .DEPTH(4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_char_valid  (char_valid),
        .i_char        (char_in),
        .o_char_ready  (char_ready),
        .o_result      (result),
        .o_carry       (carry),
        .o_result_valid(result_valid),
        .o_depth       (depth),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch);
        char_valid = 1'b1;
        char_in    = ch;
        step();
        char_valid = 1'b0;
    endtask

    // Operator transfer, then EXEC cycle, WB cycle (pulse) and back to IDLE.
    task automatic op(input string tag, input logic [7:0] ch, input logic [3:0] exp_res,
                      input logic exp_c, input logic [2:0] exp_depth);
        send(ch);
        check({tag, " exec ready"}, 32'(char_ready), 32'd0);
        check({tag, " exec valid"}, 32'(result_valid), 32'd0);
        step();
        check({tag, " wb valid"}, 32'(result_valid), 32'd1);
        check({tag, " wb ready"}, 32'(char_ready), 32'd0);
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " carry"}, 32'(carry), 32'(exp_c));
        step();
        check({tag, " idle valid"}, 32'(result_valid), 32'd0);
        check({tag, " idle ready"}, 32'(char_ready), 32'd1);
        check({tag, " depth"}, 32'(depth), 32'(exp_depth));
    endtask

    initial begin
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        step();
        step();
        check("rst ready", 32'(char_ready), 32'd1);
        check("rst result", 32'(result), 32'd0);
        check("rst carry", 32'(carry), 32'd0);
        check("rst valid", 32'(result_valid), 32'd0);
        check("rst depth", 32'(depth), 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();

        // 4 + 5 = 9
        send("4");
        send("5");
        check("t1 depth2", 32'(depth), 32'd2);
        op("t1 add", "+", 4'd9, 1'b0, 3'd1);

        // f + 2 = 0x11 -> 1 with carry; '=' peeks without popping
        send("c");
        send("f");
        send("2");
        op("t2 add", "+", 4'd1, 1'b1, 3'd1);
        send("=");
        check("t2 eq valid", 32'(result_valid), 32'd1);
        check("t2 eq result", 32'(result), 32'd1);
        check("t2 eq carry", 32'(carry), 32'd0);
        check("t2 eq depth", 32'(depth), 32'd1);
        step();
        check("t2 eq pulse end", 32'(result_valid), 32'd0);

        // 3 - 5 = -2 -> E with borrow; 9 - 4 = 5; E - 5 = 9
        send("c");
        send("3");
        send("5");
        op("t3 sub borrow", "-", 4'hE, 1'b1, 3'd1);
        send("9");
        send("4");
        op("t3 sub", "-", 4'd5, 1'b0, 3'd2);
        op("t3 sub chain", "-", 4'd9, 1'b0, 3'd1);

        // Lowercase hex digits push; uppercase is ignored
        send("c");
        send("a");
        send("A");
        check("t3 upper ignored", 32'(depth), 32'd1);
        send("b");
        op("t3 hex add", "+", 4'd5, 1'b1, 3'd1);

        // Overflow: fifth push dropped, stack intact
        send("c");
        send("1");
        send("2");
        send("3");
        send("4");
        check("t4 full err0", 32'(err), 32'd0);
        send("5");
        check("t4 depth", 32'(depth), 32'd4);
        check("t4 err", 32'(err), 32'd1);
        send("=");
        check("t4 top kept", 32'(result), 32'd4);
        send("c");
        check("t4 clr depth", 32'(depth), 32'd0);
        check("t4 clr err", 32'(err), 32'd0);
        send("=");
        check("t4 eq empty err", 32'(err), 32'd1);
        check("t4 eq empty novalid", 32'(result_valid), 32'd0);

        // Underflow on operator, then a held character across EXEC/WB
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send("7");
        send("+");
        check("t5 err", 32'(err), 32'd1);
        check("t5 depth", 32'(depth), 32'd1);
        check("t5 ready", 32'(char_ready), 32'd1);
        step();
        check("t5 nopulse", 32'(result_valid), 32'd0);
        send("8");
        char_valid = 1'b1;
        char_in    = "+";
        step();
        char_in = "9";
        check("t5 hold exec ready", 32'(char_ready), 32'd0);
        step();
        check("t5 hold wb valid", 32'(result_valid), 32'd1);
        check("t5 hold wb result", 32'(result), 32'd15);
        step();
        check("t5 hold not taken", 32'(depth), 32'd1);
        step();
        char_valid = 1'b0;
        check("t5 hold taken", 32'(depth), 32'd2);
        check("t5 err sticky", 32'(err), 32'd1);
        send("=");
        check("t5 held value", 32'(result), 32'd9);

        // Reset during EXEC abandons the operation
        send("c");
        send("2");
        send("3");
        send("+");
        check("t6 in exec", 32'(char_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6 rst depth", 32'(depth), 32'd0);
        check("t6 rst result", 32'(result), 32'd0);
        check("t6 rst ready", 32'(char_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6 no pulse", 32'(result_valid), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check("t6 post no pulse", 32'(result_valid), 32'd0);
        check("t6 post depth", 32'(depth), 32'd0);

`ifdef RPN_DUP_SWAP_EN
        // 6 dup + = 12; 1 8 swap - = 8 - 1 = 7
        send("6");
        send("d");
        check("opt dup depth", 32'(depth), 32'd2);
        op("opt dup add", "+", 4'hC, 1'b0, 3'd1);
        send("c");
        send("1");
        send("8");
        send("s");
        op("opt swap sub", "-", 4'd7, 1'b0, 3'd1);
        send("s");
        check("opt swap err", 32'(err), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
